// File: rtl/fp_div_postnorm_pkg.sv
// Shared FP-divider definitions: post-normalizer FSM encoding, exponent limits,
// canonical NaN and the registered operand record.
package fp_div_postnorm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NORM,
    ST_DENORM,
    ST_ROUND,
    ST_OUT
  } state_t;

  localparam logic signed [9:0] EXP_BIAS  = 10'sd127;
  localparam logic signed [9:0] EXP_MAX   = 10'sd255;
  localparam logic [31:0]       CANON_NAN = 32'h7FC0_0000;

  // Quotient being normalized; exp is the signed biased exponent as raw bits.
  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [26:0] mant;
    logic        sticky;
  } op_t;

  function automatic logic [31:0] fp_inf(input logic sign);
    return {sign, 8'hFF, 23'h0};
  endfunction

  function automatic logic [31:0] fp_zero(input logic sign);
    return {sign, 31'h0};
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even increment of a 24-bit significand; combinational, 0 cycles.
// No handshake: the caller samples the outputs while its operand is stable.
module fp_round_rne (
  input  logic [23:0] sig_in,
  input  logic        guard,
  input  logic        round_bit,
  input  logic        sticky,
  output logic [23:0] sig_out,
  output logic        carry,
  output logic        inexact
);

  logic        inc;
  logic [24:0] sum;

  assign inc     = guard & (round_bit | sticky | sig_in[0]);
  assign sum     = {1'b0, sig_in} + {24'd0, inc};
  assign carry   = sum[24];
  // A carry out of the hidden bit leaves 1.000..0 at the next exponent.
  assign sig_out = carry ? 24'h80_0000 : sum[23:0];
  assign inexact = guard | round_bit | sticky;

endmodule

// File: rtl/fp_div_postnorm.sv
// Divider post-normalizer: shifts, denormalizes and RNE-rounds a quotient to IEEE single.
// Latency 3 cycles plus 1 per shift; one op in flight, in_ready only when idle, result held until out_ready.
module fp_div_postnorm
  import fp_div_postnorm_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign,
  input  logic signed [9:0]  in_exp,
  input  logic [26:0]        in_mant,
  input  logic               in_sticky,
  input  logic               in_nan,
  input  logic               in_inf,
  input  logic               in_zero,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        result,
  output logic               overflow,
  output logic               underflow,
  output logic               inexact
);

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [31:0] result_q, result_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic        inx_q, inx_d;

  logic signed [9:0] e_cur;
  logic signed [9:0] rnd_exp;
  logic [23:0]       rnd_sig;
  logic              rnd_carry;
  logic              rnd_inexact;
  logic [7:0]        exp_field;

  assign e_cur = $signed(op_q.exp);

  fp_round_rne u_round (
    .sig_in    (op_q.mant[25:2]),
    .guard     (op_q.mant[1]),
    .round_bit (op_q.mant[0]),
    .sticky    (op_q.sticky),
    .sig_out   (rnd_sig),
    .carry     (rnd_carry),
    .inexact   (rnd_inexact)
  );

  assign rnd_exp   = rnd_carry ? (e_cur + 10'sd1) : e_cur;
  // Subnormals sit at e == 1, so rounding up into the hidden bit yields field 1.
  assign exp_field = rnd_sig[23] ? rnd_exp[7:0] : 8'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inx_q    <= inx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    inx_d    = inx_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d.sign   = in_sign;
          op_d.exp    = in_exp;
          op_d.mant   = in_mant;
          op_d.sticky = in_sticky;
          ovf_d       = 1'b0;
          unf_d       = 1'b0;
          inx_d       = 1'b0;
          if (in_nan) begin
            result_d = CANON_NAN;
            state_d  = ST_OUT;
          end else if (in_inf) begin
            result_d = fp_inf(in_sign);
            state_d  = ST_OUT;
          end else if (in_zero) begin
            result_d = fp_zero(in_sign);
            state_d  = ST_OUT;
          end else begin
            state_d  = ST_NORM;
          end
        end
      end

      ST_NORM: begin
        if (op_q.mant == 27'd0) begin
          state_d = ST_ROUND;
        end else if (op_q.mant[26]) begin
          op_d.mant   = op_q.mant >> 1;
          op_d.sticky = op_q.sticky | op_q.mant[0];
          op_d.exp    = op_q.exp + 10'd1;
        end else if (!op_q.mant[25] && (e_cur > 10'sd1)) begin
          op_d.mant   = op_q.mant << 1;
          op_d.exp    = op_q.exp - 10'd1;
        end else if (e_cur < 10'sd1) begin
          state_d = ST_DENORM;
        end else begin
          state_d = ST_ROUND;
        end
      end

      ST_DENORM: begin
        // Anything shifted further than the guard/round window only feeds sticky.
        if (e_cur < -10'sd25) begin
          op_d.sticky = op_q.sticky | (|op_q.mant);
          op_d.mant   = 27'd0;
          op_d.exp    = 10'd1;
          state_d     = ST_ROUND;
        end else if (e_cur < 10'sd1) begin
          op_d.mant   = op_q.mant >> 1;
          op_d.sticky = op_q.sticky | op_q.mant[0];
          op_d.exp    = op_q.exp + 10'd1;
          if (e_cur == 10'sd0) begin
            state_d = ST_ROUND;
          end
        end else begin
          state_d = ST_ROUND;
        end
      end

      ST_ROUND: begin
        state_d = ST_OUT;
        if (rnd_sig[23] && (rnd_exp >= EXP_MAX)) begin
          result_d = fp_inf(op_q.sign);
          ovf_d    = 1'b1;
          unf_d    = 1'b0;
          inx_d    = 1'b1;
        end else begin
          result_d = {op_q.sign, exp_field, rnd_sig[22:0]};
          ovf_d    = 1'b0;
          unf_d    = (exp_field == 8'd0) && rnd_inexact;
          inx_d    = rnd_inexact;
        end
      end

      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign inexact   = inx_q;

endmodule

// File: tb/tb_fp_div_postnorm.sv
// Directed-vector bench for fp_div_postnorm: result, flags and latency per vector,
// plus hand-written hold, back-to-back and mid-operation reset sequences.
module tb_fp_div_postnorm;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic signed [9:0] in_exp;
  logic [26:0]       in_mant;
  logic              in_sticky;
  logic              in_nan;
  logic              in_inf;
  logic              in_zero;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       result;
  logic              overflow;
  logic              underflow;
  logic              inexact;

  typedef struct {
    string       name;
    logic        sign;
    logic [9:0]  exp;
    logic [26:0] mant;
    logic        sticky;
    logic        nan;
    logic        inf;
    logic        zero;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
    int          lat;   // 0: latency not checked
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  fp_div_postnorm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_sticky (in_sticky),
    .in_nan    (in_nan),
    .in_inf    (in_inf),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic add_vec(input string name, input logic sign, input int e, input logic [26:0] m,
                         input logic s, input logic nan, input logic inf, input logic zero,
                         input logic [31:0] res, input logic ovf, input logic unf,
                         input logic inx, input int lat);
    vec_t v;
    v.name = name; v.sign = sign; v.exp = 10'(e); v.mant = m; v.sticky = s;
    v.nan = nan; v.inf = inf; v.zero = zero;
    v.res = res; v.ovf = ovf; v.unf = unf; v.inx = inx; v.lat = lat;
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    in_sign   = v.sign;
    in_exp    = v.exp;
    in_mant   = v.mant;
    in_sticky = v.sticky;
    in_nan    = v.nan;
    in_inf    = v.inf;
    in_zero   = v.zero;
  endtask

  // Accept on the next edge, then count edges (accept edge = 1) until out_valid.
  task automatic accept_and_wait(input vec_t v, output int lat);
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    out_ready = 1'b1;
    accept_and_wait(v, lat);
    check({v.name, " out_valid"}, {31'd0, out_valid}, 32'd1);
    check({v.name, " result"}, result, v.res);
    check({v.name, " flags"}, {29'd0, overflow, underflow, inexact}, {29'd0, v.ovf, v.unf, v.inx});
    if (v.lat != 0) check({v.name, " latency"}, lat, v.lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    vec_t v;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_sign = 1'b0; in_exp = '0; in_mant = '0; in_sticky = 1'b0;
    in_nan = 1'b0; in_inf = 1'b0; in_zero = 1'b0;

    //       name          sg  exp    mant          s  nan inf zer result        ov un ix lat
    add_vec("two",         0,  128,  27'h2000000, 0, 0, 0, 0, 32'h40000000, 0, 0, 0, 3);
    add_vec("lshift1",     0,  127,  27'h1555555, 1, 0, 0, 0, 32'h3F2AAAAB, 0, 0, 1, 4);
    add_vec("ovf_big",     0,  300,  27'h2000000, 0, 0, 0, 0, 32'h7F800000, 1, 0, 1, 3);
    add_vec("denorm11",    0,  -10,  27'h2000000, 0, 0, 0, 0, 32'h00001000, 0, 0, 0, 14);
    add_vec("zero_quot",   1,  100,  27'h0000000, 0, 0, 0, 0, 32'h80000000, 0, 0, 0, 3);
    add_vec("rshift1",     0,  127,  27'h4000000, 0, 0, 0, 0, 32'h40000000, 0, 0, 0, 4);
    add_vec("tie_even",    0,  127,  27'h2000002, 0, 0, 0, 0, 32'h3F800000, 0, 0, 1, 3);
    add_vec("tie_odd",     0,  127,  27'h2000006, 0, 0, 0, 0, 32'h3F800002, 0, 0, 1, 3);
    add_vec("carry_out",   1,  127,  27'h3FFFFFF, 0, 0, 0, 0, 32'hC0000000, 0, 0, 1, 3);
    add_vec("carry_ovf",   0,  254,  27'h3FFFFFF, 0, 0, 0, 0, 32'h7F800000, 1, 0, 1, 3);
    add_vec("dn_to_norm",  0,  0,    27'h3FFFFFF, 0, 0, 0, 0, 32'h00800000, 0, 0, 1, 4);
    add_vec("flush",       1,  -100, 27'h2000000, 0, 0, 0, 0, 32'h80000000, 0, 1, 1, 4);
    add_vec("dn_exact",    0,  -1,   27'h2000000, 0, 0, 0, 0, 32'h00200000, 0, 0, 0, 5);
    add_vec("dn_inexact",  0,  -1,   27'h2000001, 0, 0, 0, 0, 32'h00200000, 0, 1, 1, 5);
    add_vec("e1_subnorm",  0,  1,    27'h1000000, 0, 0, 0, 0, 32'h00400000, 0, 0, 0, 3);
    add_vec("lshift25",    0,  127,  27'h0000001, 0, 0, 0, 0, 32'h33000000, 0, 0, 0, 28);
    add_vec("inf_neg",     1,  5,    27'h2000000, 1, 0, 1, 0, 32'hFF800000, 0, 0, 0, 0);
    add_vec("inf_over_z",  0,  5,    27'h2000000, 0, 0, 1, 1, 32'h7F800000, 0, 0, 0, 0);
    add_vec("zero_flag",   1,  300,  27'h3FFFFFF, 1, 0, 0, 1, 32'h80000000, 0, 0, 0, 0);
    add_vec("nan_neg",     1,  5,    27'h2000000, 1, 1, 0, 1, 32'h7FC00000, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst result", result, 32'd0);
    check("rst flags", {29'd0, overflow, underflow, inexact}, 32'd0);
    rst_n = 1'b1;

    foreach (vq[i]) run_vec(vq[i]);

    // NaN beats inf; output held under backpressure while a new operand waits.
    v = vq[0];
    v.name = "nan_hold"; v.nan = 1'b1; v.inf = 1'b1;
    out_ready = 1'b0;
    accept_and_wait(v, lat);
    drive(vq[0]);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("hold result", result, 32'h7FC00000);
      check("hold valid/ready", {30'd0, out_valid, in_ready}, 32'd2);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("after hs ready/valid", {30'd0, out_valid, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("next accepted", {31'd0, in_ready}, 32'd0);
    lat = 2;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b result", result, 32'h40000000);
    @(posedge clk);
    #1;

    // Reset while in NORM of the left-shift case abandons it.
    @(negedge clk);
    drive(vq[1]);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid-rst ready/valid", {30'd0, out_valid, in_ready}, 32'd1);
    check("mid-rst result", result, 32'd0);
    check("mid-rst flags", {29'd0, overflow, underflow, inexact}, 32'd0);
    lat = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat++;
    end
    check("mid-rst no output", lat, 0);
    run_vec(vq[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
